if_stage: RTL

- Instruction-fetch stage: owns the PC, drives the synchronous instruction ROM, and presents the fetched instruction (address + word) to the decode stage.
- Consumes decode's branch redirect and stall request, and the pipeline controller's flush.
- MIPS-style single delay slot: the instruction fetched while a branch sits in decode always executes.
- Contains a one-entry hold buffer so a stalled instruction survives the ROM's one-cycle read latency.

---
 rtl/if_stage.sv | 83 ++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with a single delay slot and a one-entry stall hold buffer.
//
// Owns the PC, drives a synchronous instruction ROM (one-cycle read latency) and
// presents {id_valid, id_addr, id_inst} to decode.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   stall              freeze fetch and the decode-facing outputs
//   flush, flush_pc    controller redirect; kills the in-flight fetch
//   branch_flag/addr   decode redirect; the instruction already fetched still executes
//   rom_en, rom_addr   ROM read request (rom_addr is the pc register)
//   rom_data           ROM word for the address presented on the previous cycle
//   id_valid/addr/inst instruction handed to decode (id_inst is 0 when not valid)

module if_stage #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_addr,
    output logic [INST_W-1:0] id_inst
);

    localparam int unsigned INST_BYTES = 4;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic              valid_q;
    logic [INST_W-1:0] hold_q;
    logic              held_q;

    // Fetch state: flush > stall > branch > sequential.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            hold_q     <= '0;
            held_q     <= 1'b0;
        end else if (flush) begin
            pc         <= flush_pc;
            fetch_pc_q <= pc;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
        end else if (stall) begin
            // Capture the word on the first stall cycle only; the ROM output moves
            // on to the pc address afterwards.
            if (!held_q) begin
                hold_q <= rom_data;
                held_q <= 1'b1;
            end
        end else begin
            fetch_pc_q <= pc;
            valid_q    <= 1'b1;
            held_q     <= 1'b0;
            pc         <= branch_flag ? branch_addr : pc + ADDR_W'(INST_BYTES);
        end
    end

    // Decode-facing and ROM-facing outputs.
    always_comb begin
        rom_en   = rst;
        rom_addr = pc;
        id_addr  = fetch_pc_q;
        id_valid = valid_q;
        id_inst  = '0;
        if (valid_q) begin
            id_inst = held_q ? hold_q : rom_data;
        end
    end

endmodule
